// File: rtl/ram_port_arbiter.sv
// Controller and round-robin two-port arbiter for the 32x32 single-port data RAM.
// Optionally zero-fills the RAM after reset, then issues one registered command per cycle.
module ram_port_arbiter #(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_p0,
   input  logic        req_p1,
   input  logic [4:0]  addr_p0,
   input  logic [4:0]  addr_p1,
   input  logic        we_p0,
   input  logic        we_p1,
   input  logic [31:0] wdata_p0,
   input  logic [31:0] wdata_p1,
   output logic        gnt_p0,
   output logic        gnt_p1,
   output logic        rvalid_p0,
   output logic        rvalid_p1,
   output logic [31:0] rdata,
   output logic        init_done,
   output logic [4:0]  ram_addr,
   output logic        ram_rw,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout
);

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

   localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

   state_e      state_q, state_d;
   logic [4:0]  clr_cnt_q, clr_cnt_d;
   logic        last_p1_q, last_p1_d;
   logic        ram_rw_q, ram_rw_d;
   logic [4:0]  ram_addr_q, ram_addr_d;
   logic [31:0] ram_din_q, ram_din_d;
   logic        s1_vld_q, s1_vld_d;
   logic        s1_port_q, s1_port_d;
   logic        s2_vld_q;
   logic        s2_port_q;

   logic [4:0]  sel_addr;
   logic        sel_we;
   logic [31:0] sel_wdata;

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      last_p1_d  = last_p1_q;
      ram_rw_d   = 1'b1;
      ram_addr_d = 5'd0;
      ram_din_d  = 32'd0;
      s1_vld_d   = 1'b0;
      s1_port_d  = 1'b0;
      gnt_p0     = 1'b0;
      gnt_p1     = 1'b0;
      sel_addr   = gnt_p1 ? addr_p1 : addr_p0;
      sel_we     = 1'b0;
      sel_wdata  = 32'd0;
      case (state_q)
         ST_INIT: begin
            ram_rw_d   = 1'b0;
            ram_addr_d = clr_cnt_q;
            clr_cnt_d  = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) state_d = ST_RUN;
         end
         ST_RUN: begin
            // On a tie, last_p1_q selects the port that did not win last time.
            gnt_p0    = rst_n && req_p0 && (!req_p1 || last_p1_q);
            gnt_p1    = rst_n && req_p1 && (!req_p0 || !last_p1_q);
            sel_addr  = gnt_p1 ? addr_p1 : addr_p0;
            sel_we    = gnt_p1 ? we_p1 : we_p0;
            sel_wdata = gnt_p1 ? wdata_p1 : wdata_p0;
            if (gnt_p0 || gnt_p1) begin
               last_p1_d = gnt_p1;
               s1_vld_d  = !sel_we;
               s1_port_d = gnt_p1;
               if (sel_we) begin
                  ram_rw_d   = 1'b0;
                  ram_addr_d = sel_addr;
                  ram_din_d  = sel_wdata;
               end else begin
                  // The RAM reads word address-1, so the address is pre-incremented.
                  ram_addr_d = sel_addr + 5'd1;
               end
            end
         end
         default: state_d = RST_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         clr_cnt_q  <= 5'd0;
         last_p1_q  <= 1'b1;
         ram_rw_q   <= 1'b1;
         ram_addr_q <= 5'd0;
         ram_din_q  <= 32'd0;
         s1_vld_q   <= 1'b0;
         s1_port_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_port_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         last_p1_q  <= last_p1_d;
         ram_rw_q   <= ram_rw_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         s1_vld_q   <= s1_vld_d;
         s1_port_q  <= s1_port_d;
         s2_vld_q   <= s1_vld_q;
         s2_port_q  <= s1_port_q;
      end
   end

   assign ram_rw    = ram_rw_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign rdata     = ram_dout;
   assign init_done = (state_q == ST_RUN);
   assign rvalid_p0 = s2_vld_q && !s2_port_q;
   assign rvalid_p1 = s2_vld_q && s2_port_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x32 RAM (registered read of address-1).
// A second instance with CLEAR_ON_RESET=0 covers the no-clear start-up.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_p0, req_p1, we_p0, we_p1;
   logic [4:0]  addr_p0, addr_p1;
   logic [31:0] wdata_p0, wdata_p1;
   logic        gnt_p0, gnt_p1, rvalid_p0, rvalid_p1, init_done;
   logic [31:0] rdata;
   logic [4:0]  ram_addr;
   logic        ram_rw;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   logic        rst_n_b;
   logic        req_p1_b;
   logic [4:0]  addr_p1_b;
   logic        gnt_p0_b, gnt_p1_b, rvalid_p0_b, rvalid_p1_b, init_done_b;
   logic [31:0] rdata_b, ram_din_b;
   logic [4:0]  ram_addr_b;
   logic        ram_rw_b;
   logic [31:0] ram_dout_b;

   logic [31:0] mem [32];
   logic [4:0]  rd_a;
   logic [31:0] exp_q [$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.CLEAR_ON_RESET(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_p0(req_p0), .req_p1(req_p1), .addr_p0(addr_p0), .addr_p1(addr_p1),
      .we_p0(we_p0), .we_p1(we_p1), .wdata_p0(wdata_p0), .wdata_p1(wdata_p1),
      .gnt_p0(gnt_p0), .gnt_p1(gnt_p1), .rvalid_p0(rvalid_p0), .rvalid_p1(rvalid_p1),
      .rdata(rdata), .init_done(init_done),
      .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   ram_port_arbiter #(.CLEAR_ON_RESET(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b),
      .req_p0(1'b0), .req_p1(req_p1_b), .addr_p0(5'd0), .addr_p1(addr_p1_b),
      .we_p0(1'b0), .we_p1(1'b0), .wdata_p0(32'd0), .wdata_p1(32'd0),
      .gnt_p0(gnt_p0_b), .gnt_p1(gnt_p1_b), .rvalid_p0(rvalid_p0_b), .rvalid_p1(rvalid_p1_b),
      .rdata(rdata_b), .init_done(init_done_b),
      .ram_addr(ram_addr_b), .ram_rw(ram_rw_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b)
   );

   assign ram_dout_b = 32'd0;

   // RAM model: write when readWrite=0, otherwise register word address-1.
   assign rd_a = ram_addr - 5'd1;
   always @(posedge clk) begin
      if (!ram_rw) mem[ram_addr] <= ram_din;
      else         ram_dout <= mem[rd_a];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_ret(input logic port);
      logic [31:0] e;
      chk("rvalid_p0", {31'd0, rvalid_p0}, {31'd0, !port});
      chk("rvalid_p1", {31'd0, rvalid_p1}, {31'd0, port});
      if (exp_q.size() == 0) begin
         chk("exp_q_nonempty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("rdata", rdata, e);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_p0 = 1'b0; req_p1 = 1'b0; we_p0 = 1'b0; we_p1 = 1'b0;
      addr_p0 = 5'd0; addr_p1 = 5'd0; wdata_p0 = 32'd0; wdata_p1 = 32'd0;
      rst_n_b = 1'b0; req_p1_b = 1'b1; addr_p1_b = 5'd3;
      ram_dout = 32'd0;

      // Reset values
      repeat (3) tick();
      chk("rst_ram_rw", {31'd0, ram_rw}, 32'd1);
      chk("rst_ram_addr", {27'd0, ram_addr}, 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid_p1, rvalid_p0}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);

      // Release reset with a p0 read already pending; clear runs 32 cycles
      req_p0 = 1'b1; we_p0 = 1'b0; addr_p0 = 5'd0; rst_n = 1'b1;
      settle();
      chk("init_gnt_p0", {31'd0, gnt_p0}, 32'd0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk("init_ram_rw", {31'd0, ram_rw}, 32'd0);
         chk("init_ram_addr", {27'd0, ram_addr}, k - 1);
         chk("init_ram_din", ram_din, 32'd0);
         chk("init_done", {31'd0, init_done}, (k == 32) ? 32'd1 : 32'd0);
         if (k < 32) chk("init_gnt_held", {31'd0, gnt_p0}, 32'd0);
      end

      // Read back all 32 words via p0, one per cycle
      for (int i = 0; i < 32; i++) begin
         addr_p0 = i[4:0];
         settle();
         chk("rb_gnt_p0", {31'd0, gnt_p0}, 32'd1);
         chk("rb_gnt_p1", {31'd0, gnt_p1}, 32'd0);
         exp_q.push_back(32'd0);
         if (i >= 1) begin
            chk("rb_ram_rw", {31'd0, ram_rw}, 32'd1);
            chk("rb_ram_addr", {27'd0, ram_addr}, i);
         end
         if (i >= 2) expect_ret(1'b0);
         tick();
      end
      req_p0 = 1'b0;
      settle();
      chk("rb_tail_gnt", {30'd0, gnt_p1, gnt_p0}, 32'd0);
      chk("rb_tail_addr", {27'd0, ram_addr}, 32'd0);
      expect_ret(1'b0);
      tick();
      expect_ret(1'b0);
      chk("idle_ram_rw", {31'd0, ram_rw}, 32'd1);
      tick();
      chk("rb_done_rvalid", {30'd0, rvalid_p1, rvalid_p0}, 32'd0);
      chk("rb_q_empty", exp_q.size(), 32'd0);

      // p0 writes DEADBEEF to 5, then reads it back immediately
      req_p0 = 1'b1; we_p0 = 1'b1; addr_p0 = 5'd5; wdata_p0 = 32'hDEADBEEF;
      settle();
      chk("wr5_gnt", {31'd0, gnt_p0}, 32'd1);
      tick();
      we_p0 = 1'b0;
      settle();
      chk("rd5_gnt", {31'd0, gnt_p0}, 32'd1);
      chk("wr5_ram_rw", {31'd0, ram_rw}, 32'd0);
      chk("wr5_ram_addr", {27'd0, ram_addr}, 32'd5);
      chk("wr5_ram_din", ram_din, 32'hDEADBEEF);
      chk("wr5_no_rvalid", {31'd0, rvalid_p0}, 32'd0);
      exp_q.push_back(32'hDEADBEEF);
      tick();
      req_p0 = 1'b0;
      settle();
      chk("rd5_ram_rw", {31'd0, ram_rw}, 32'd1);
      chk("rd5_ram_addr", {27'd0, ram_addr}, 32'd6);
      chk("rd5_early", {31'd0, rvalid_p0}, 32'd0);
      tick();
      expect_ret(1'b0);
      chk("idle_ram_addr", {27'd0, ram_addr}, 32'd0);
      tick();
      chk("rd5_pulse_end", {31'd0, rvalid_p0}, 32'd0);

      // p1 writes 12345678 to 31, then reads it (address wraps to 0)
      req_p1 = 1'b1; we_p1 = 1'b1; addr_p1 = 5'd31; wdata_p1 = 32'h12345678;
      settle();
      chk("wr31_gnt_p1", {31'd0, gnt_p1}, 32'd1);
      chk("wr31_gnt_p0", {31'd0, gnt_p0}, 32'd0);
      tick();
      we_p1 = 1'b0;
      settle();
      chk("rd31_gnt", {31'd0, gnt_p1}, 32'd1);
      chk("wr31_ram_din", ram_din, 32'h12345678);
      chk("wr31_ram_addr", {27'd0, ram_addr}, 32'd31);
      exp_q.push_back(32'h12345678);
      tick();
      req_p1 = 1'b0;
      settle();
      chk("rd31_ram_addr", {27'd0, ram_addr}, 32'd0);
      chk("rd31_ram_rw", {31'd0, ram_rw}, 32'd1);
      tick();
      expect_ret(1'b1);
      tick();

      // Both ports read continuously: strict alternation starting with p0
      req_p0 = 1'b1; we_p0 = 1'b0; addr_p0 = 5'd5;
      req_p1 = 1'b1; we_p1 = 1'b0; addr_p1 = 5'd31;
      for (int j = 0; j < 6; j++) begin
         settle();
         chk("rr_gnt_p0", {31'd0, gnt_p0}, (j % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_gnt_p1", {31'd0, gnt_p1}, (j % 2 == 1) ? 32'd1 : 32'd0);
         exp_q.push_back((j % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
         if (j >= 2) expect_ret(j % 2 == 1);
         tick();
      end
      req_p0 = 1'b0; req_p1 = 1'b0;
      settle();
      expect_ret(1'b0);
      tick();
      expect_ret(1'b1);
      tick();
      chk("rr_done_rvalid", {30'd0, rvalid_p1, rvalid_p0}, 32'd0);

      // Reset right after a p0 read grant: the read never returns, clear restarts
      req_p0 = 1'b1; addr_p0 = 5'd5;
      settle();
      chk("rst_rd_gnt", {31'd0, gnt_p0}, 32'd1);
      tick();
      req_p0 = 1'b0; rst_n = 1'b0;
      settle();
      chk("rst_cmd_addr", {27'd0, ram_addr}, 32'd6);
      tick();
      chk("rst2_ram_rw", {31'd0, ram_rw}, 32'd1);
      chk("rst2_no_rvalid", {31'd0, rvalid_p0}, 32'd0);
      chk("rst2_init_done", {31'd0, init_done}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("reinit_rw", {31'd0, ram_rw}, 32'd0);
      chk("reinit_addr0", {27'd0, ram_addr}, 32'd0);
      chk("reinit_no_rvalid", {31'd0, rvalid_p0}, 32'd0);
      tick();
      chk("reinit_addr1", {27'd0, ram_addr}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("midinit_rst_rw", {31'd0, ram_rw}, 32'd1);
      rst_n = 1'b1;
      tick();
      chk("midinit_restart", {27'd0, ram_addr}, 32'd0);
      tick();
      chk("midinit_addr1", {27'd0, ram_addr}, 32'd1);

      // No-clear instance: p1 held through reset is granted on release
      rst_n_b = 1'b1;
      settle();
      chk("b_init_done", {31'd0, init_done_b}, 32'd1);
      chk("b_gnt_p1", {31'd0, gnt_p1_b}, 32'd1);
      chk("b_gnt_p0", {31'd0, gnt_p0_b}, 32'd0);
      tick();
      req_p1_b = 1'b0;
      settle();
      chk("b_ram_rw", {31'd0, ram_rw_b}, 32'd1);
      chk("b_ram_addr", {27'd0, ram_addr_b}, 32'd4);
      tick();
      chk("b_rvalid_p1", {31'd0, rvalid_p1_b}, 32'd1);
      chk("b_rvalid_p0", {31'd0, rvalid_p0_b}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Controller and two-port arbiter for the 32×32 single-port data RAM (5-bit word address, `readWrite` 1 = read / 0 = write, registered read data).
- Optionally clears all 32 words after reset.
- Then grants two requesters round-robin access, with one RAM operation per cycle.
- Registers every RAM command and returns read data with a per-port valid strobe.
- Sits between the core's memory-stage / loader requesters and the RAM instance; it is the only driver of the RAM inputs.

## Interface
Parameters:
- `CLEAR_ON_RESET`, default 1: 1 = run a 32-cycle zero-fill after reset; 0 = go straight to RUN.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_p0`, `req_p1` in 1: access request, held until granted.
- `addr_p0`, `addr_p1` in 5: word address.
- `we_p0`, `we_p1` in 1: 1 = write, 0 = read.
- `wdata_p0`, `wdata_p1` in 32: write data.
- `gnt_p0`, `gnt_p1` out 1: combinational accept; the request is consumed at the end of this cycle.
- `rvalid_p0`, `rvalid_p1` out 1: read data valid for that port, one-cycle pulse.
- `rdata` out 32: shared read data; equals `ram_dout`.
- `init_done` out 1: high once the controller is in RUN.
- `ram_addr` out 5: to RAM `address`.
- `ram_rw` out 1: to RAM `readWrite`.
- `ram_din` out 32: to RAM `dataIN`.
- `ram_dout` in 32: from RAM `dataOUT`.

## Operation
- Clock is `clk`. Reset is synchronous, active-low (`rst_n`).

States:
- INIT: entered on reset when `CLEAR_ON_RESET`=1.
  - 5-bit counter `clr_cnt` starts at 0.
  - Each cycle registers `ram_rw`=0, `ram_addr`=`clr_cnt`, `ram_din`=0, then increments the counter.
  - After issuing address 31, go to RUN.
  - `gnt_*` are held 0 throughout.
- RUN: normal arbitration. RUN is left only by reset.

Arbitration (RUN):
- One request asserted: that port is granted in the same cycle.
- Both asserted: grant the port that was not granted most recently.
- The last-grant pointer updates only when a grant occurs. Reset value is p1, so p0 wins the first tie.
- At most one `gnt_*` is high per cycle.

Command issue (registered at the end of the grant cycle):
- Write: `ram_rw`=0, `ram_addr`=addr, `ram_din`=wdata.
- Read: `ram_rw`=1, `ram_addr`=(addr+1) mod 32.
  - The RAM returns word `address-1` on reads; the +1 compensates.
  - Address 31 is issued as 0, and the RAM's 5-bit `address-1` wraps back to word 31.
- No grant (idle): `ram_rw`=1, `ram_addr`=0, `ram_din`=0.
  - The RAM writes whenever `readWrite`=0, so `ram_rw` must never be 0 except for a granted write or an INIT step.

Read return:
- A 2-stage shift register carries {valid, port id} for each read.
- `rvalid_pX` pulses when the entry exits stage 2.
- Writes produce no `rvalid`.

Reset values:
- `ram_rw`=1, `ram_addr`=0, `ram_din`=0.
- `rvalid_*`=0; return pipeline cleared.
- `init_done`=0 if `CLEAR_ON_RESET`=1, else 1 from the first cycle after reset.
- `clr_cnt`=0; last-grant pointer = p1.

## Timing
- Request in cycle C with `gnt_pX`=1:
  - RAM command registered at the end of C and presented during C+1.
  - RAM executes at the end of C+1.
  - Read: `rvalid_pX`=1 and `rdata` valid during C+2. Latency 2; back-to-back reads give one `rvalid` per cycle.
  - Write: committed at the end of C+1. A read of the same address granted in C+1 or later returns the new data, because commands execute in order.
- Requesters may change addr/we/wdata or drop `req` in cycle C+1; they are not sampled again.
- INIT: 32 write cycles follow the reset-release edge. `init_done` rises in the first RUN cycle; the first grant is possible in that cycle.
- Reset asserted mid-operation:
  - A command already registered is still executed by the RAM at the first reset edge.
  - From the next cycle `ram_rw`=1, and in-flight reads give no `rvalid`.
  - Reset during INIT restarts the clear at address 0.
- A `req` asserted during INIT waits and is granted in the first RUN cycle.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, then read all 32 words via p0 → `init_done` high after 32 cycles, every `rdata`=0, `ram_rw` never 0 outside INIT and granted writes.
- p0 writes 0xDEADBEEF to addr 5 in cycle C; p0 reads addr 5 in C+1 → `ram_addr`=6 during C+2; `rvalid_p0`=1, `rdata`=0xDEADBEEF in C+3.
- p1 writes 0x12345678 to addr 31, then reads addr 31 → read issued with `ram_addr`=0; `rdata`=0x12345678 two cycles after the read grant.
- Both ports request reads continuously for 6 cycles after reset → grants p0,p1,p0,p1,p0,p1; `rvalid` alternates with 2-cycle lag; no cycle has two grants.
- Assert `rst_n`=0 in the cycle after a p0 read grant → no `rvalid_p0`; `ram_rw`=1 from the second reset cycle; INIT restarts at address 0.
- `CLEAR_ON_RESET`=0 with p1 requesting during reset → `init_done`=1 and `gnt_p1`=1 in the first cycle after `rst_n` rises.
